// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multi-cycle register machine with a unified
// memory, a program-load port and valid/ready input/output channels.
module cpu_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int REG_W  = 2,
    localparam int IW    = 4 + 2 * REG_W + DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [IW-1:0]     prog_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [IW-1:0]     ir,
    output logic [3:0]        flags,
    output logic              halted,
    input  logic [REG_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NREG  = 2 ** REG_W;
    localparam logic [DATA_W-1:0] DW_C = DATA_W[DATA_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_IN, S_OUT, S_HALT
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     mem [DEPTH];
    logic [DATA_W-1:0] rf_q [NREG];
    logic [ADDR_W-1:0] pc_q;
    logic [IW-1:0]     ir_q;
    logic [3:0]        flags_q;
    logic [DATA_W-1:0] out_q;
    logic              ov_q;
    logic              rdy_q;
    logic              halt_q;

    logic [3:0]        opc;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] tgt;
    logic [DATA_W-1:0] rd_v;
    logic [DATA_W-1:0] rs_v;

    assign opc  = ir_q[IW-1 -: 4];
    assign rd   = ir_q[IW-5 -: REG_W];
    assign rs   = ir_q[IW-5-REG_W -: REG_W];
    assign imm  = ir_q[DATA_W-1:0];
    assign tgt  = imm[ADDR_W-1:0];
    assign rd_v = rf_q[rd];
    assign rs_v = rf_q[rs];

    logic [DATA_W:0]     add_d;
    logic [DATA_W:0]     sub_d;
    logic [DATA_W-1:0]   sh_d;
    logic [2*DATA_W-1:0] rol_w;
    logic [DATA_W-1:0]   rol_d;
    logic                take_d;

    // Top bit of the widened difference is the borrow.
    assign add_d = {1'b0, rd_v} + {1'b0, rs_v};
    assign sub_d = {1'b0, rd_v} - {1'b0, rs_v};
    assign sh_d  = imm % DW_C;
    assign rol_w = {rd_v, rd_v} << sh_d;
    assign rol_d = rol_w[2*DATA_W-1 -: DATA_W];

    always_comb begin
        take_d = 1'b0;
        unique case (rd[1:0])
            2'd0: take_d = flags_q[0];
            2'd1: take_d = flags_q[1];
            2'd2: take_d = flags_q[2];
            2'd3: take_d = flags_q[3];
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && prog_we)
            mem[prog_addr] <= prog_data;
        else if (state_q == S_EXEC && opc == 4'h3)
            mem[tgt] <= IW'(rd_v);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            rdy_q   <= 1'b0;
            halt_q  <= 1'b0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE:
                    if (run_en) state_q <= S_FETCH;
                S_FETCH:
                    if (!run_en) begin
                        state_q <= S_IDLE;
                    end else begin
                        ir_q    <= mem[pc_q];
                        pc_q    <= pc_q + 1'b1;
                        state_q <= S_EXEC;
                    end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    unique case (opc)
                        4'h1: rf_q[rd] <= imm;
                        4'h2: rf_q[rd] <= mem[tgt][DATA_W-1:0];
                        4'h4: rf_q[rd] <= rs_v;
                        4'h5: begin
                            rf_q[rd] <= add_d[DATA_W-1:0];
                            flags_q  <= {add_d[DATA_W], flags_q[2:1],
                                         add_d[DATA_W-1:0] == '0};
                        end
                        4'h6: begin
                            rf_q[rd] <= sub_d[DATA_W-1:0];
                            flags_q  <= {sub_d[DATA_W], flags_q[2:1],
                                         sub_d[DATA_W-1:0] == '0};
                        end
                        4'h7: begin
                            rf_q[rd] <= rd_v & rs_v;
                            flags_q  <= {1'b0, flags_q[2:1],
                                         (rd_v & rs_v) == '0};
                        end
                        4'h8: begin
                            rf_q[rd] <= rd_v | rs_v;
                            flags_q  <= {1'b0, flags_q[2:1],
                                         (rd_v | rs_v) == '0};
                        end
                        4'h9: begin
                            rf_q[rd] <= rd_v ^ rs_v;
                            flags_q  <= {1'b0, flags_q[2:1],
                                         (rd_v ^ rs_v) == '0};
                        end
                        4'hA: begin
                            rf_q[rd] <= rol_d;
                            flags_q  <= {flags_q[3:1], rol_d == '0};
                        end
                        4'hB: flags_q <= {sub_d[DATA_W], rd_v < rs_v,
                                          rd_v > rs_v, rd_v == rs_v};
                        4'hC: pc_q <= tgt;
                        4'hD: if (take_d) pc_q <= tgt;
                        4'hE:
                            if (rs[0]) begin
                                out_q   <= rd_v;
                                ov_q    <= 1'b1;
                                state_q <= S_OUT;
                            end else begin
                                rdy_q   <= 1'b1;
                                state_q <= S_IN;
                            end
                        4'hF: begin
                            halt_q  <= 1'b1;
                            state_q <= S_HALT;
                        end
                        default: ;
                    endcase
                end
                S_IN:
                    if (in_valid && rdy_q) begin
                        rf_q[rd] <= in_data;
                        rdy_q    <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                S_OUT:
                    if (ov_q && out_ready) begin
                        ov_q    <= 1'b0;
                        state_q <= S_FETCH;
                    end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_data  = out_q;
    assign out_valid = ov_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign flags     = flags_q;
    assign halted    = halt_q;
    assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_cpu_core_param.sv
// Bench for cpu_core_param: ALU vector table, directed multi-cycle sequences
// and random straight-line programs checked against an ISA-level interpreter.
module tb_cpu_core_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  pc;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic        halted;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    cpu_core_param dut (
        .clk(clk), .reset(reset), .run_en(run_en),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .ir(ir), .flags(flags), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_in = 0;
    int n_out = 0;
    int last_out = 0;

    always @(posedge clk) begin
        if (in_valid && in_ready) n_in++;
        if (out_valid && out_ready) begin
            n_out++;
            last_out = out_data;
        end
    end

    logic [15:0] img [16];

    typedef struct {
        int op; int a; int b; int imm; int er; int ef;
    } vec_t;
    vec_t tbl [12];

    int e_reg [4];
    int e_fl;
    int e_pc;

    function automatic logic [15:0] enc(int op, int rd, int rs, int imm);
        return {op[3:0], rd[1:0], rs[1:0], imm[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; run_en = 1'b0; prog_we = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic load();
        for (int a = 0; a < 16; a++) begin
            prog_we = 1'b1;
            prog_addr = 4'(a);
            prog_data = img[a];
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic fill(logic [15:0] w);
        for (int a = 0; a < 16; a++) img[a] = w;
    endtask

    task automatic run_halt(int budget);
        run_en = 1'b1;
        for (int k = 0; k < budget && !halted; k++) tick();
        chk("halt_reached", int'(halted), 1);
    endtask

    task automatic wait_ov(string name, int budget);
        for (int k = 0; k < budget && !out_valid; k++) tick();
        chk(name, int'(out_valid), 1);
    endtask

    task automatic reg_rd(int i, output int v);
        dbg_sel = 2'(i);
        #1;
        v = int'(dbg_data);
    endtask

    // ISA-level interpreter over img[]: executes until HLT or step limit.
    task automatic model_run();
        int r [4];
        int mm [16];
        int mpc, w, op, rd, rs, imm, t, a, b, s, sh, fc, fl, fg, fz, stop, tk;
        for (int i = 0; i < 4; i++) r[i] = 0;
        for (int i = 0; i < 16; i++) mm[i] = int'(img[i]);
        mpc = 0; fc = 0; fl = 0; fg = 0; fz = 0; stop = 0;
        for (int step = 0; step < 100 && stop == 0; step++) begin
            w = mm[mpc];
            mpc = (mpc + 1) % 16;
            op = (w >> 12) & 15; rd = (w >> 10) & 3;
            rs = (w >> 8) & 3; imm = w & 255; t = imm & 15;
            a = r[rd]; b = r[rs];
            case (op)
                1: r[rd] = imm;
                2: r[rd] = mm[t] & 255;
                3: mm[t] = a;
                4: r[rd] = b;
                5: begin
                    s = a + b; fc = (s > 255); r[rd] = s % 256;
                    fz = (r[rd] == 0);
                end
                6: begin
                    fc = (a < b); r[rd] = (a - b + 256) % 256;
                    fz = (r[rd] == 0);
                end
                7: begin r[rd] = a & b; fc = 0; fz = (r[rd] == 0); end
                8: begin r[rd] = a | b; fc = 0; fz = (r[rd] == 0); end
                9: begin r[rd] = a ^ b; fc = 0; fz = (r[rd] == 0); end
                10: begin
                    sh = imm % 8;
                    r[rd] = ((a << sh) | (a >> (8 - sh))) & 255;
                    fz = (r[rd] == 0);
                end
                11: begin
                    fz = (a == b); fg = (a > b); fl = (a < b); fc = (a < b);
                end
                12: mpc = t;
                13: begin
                    tk = (rd == 0) ? fz : (rd == 1) ? fg : (rd == 2) ? fl : fc;
                    if (tk != 0) mpc = t;
                end
                14, 15: stop = 1;
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) e_reg[i] = r[i];
        e_fl = fc * 8 + fl * 4 + fg * 2 + fz;
        e_pc = mpc;
    endtask

    int v;
    int p0;
    int b_in;
    int b_out;
    int op;

    initial begin
        reset = 1'b0; run_en = 1'b0; prog_we = 1'b0; prog_addr = '0;
        prog_data = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        dbg_sel = '0;
        #12;
        chk("rst_pc", int'(pc), 0);
        chk("rst_ir", int'(ir), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_out_data", int'(out_data), 0);
        for (int i = 0; i < 4; i++) begin
            reg_rd(i, v);
            chk($sformatf("rst_r%0d", i), v, 0);
        end
        reset = 1'b1;
        tick();

        tbl[0]  = '{5, 'hFF, 'h01, 0, 'h00, 'b1001};
        tbl[1]  = '{5, 'h12, 'h34, 0, 'h46, 'b0000};
        tbl[2]  = '{6, 'h00, 'h01, 0, 'hFF, 'b1000};
        tbl[3]  = '{6, 'h05, 'h05, 0, 'h00, 'b0001};
        tbl[4]  = '{7, 'hF0, 'h0F, 0, 'h00, 'b0001};
        tbl[5]  = '{8, 'hA0, 'h05, 0, 'hA5, 'b0000};
        tbl[6]  = '{9, 'hFF, 'hFF, 0, 'h00, 'b0001};
        tbl[7]  = '{10, 'h81, 'h00, 9, 'h03, 'b0000};
        tbl[8]  = '{11, 'h03, 'h07, 0, 'h03, 'b1100};
        tbl[9]  = '{11, 'h09, 'h02, 0, 'h09, 'b0010};
        tbl[10] = '{11, 'h04, 'h04, 0, 'h04, 'b0001};
        tbl[11] = '{4, 'h01, 'h77, 0, 'h77, 'b0000};
        for (int i = 0; i < 12; i++) begin
            do_reset();
            fill(enc(15, 0, 0, 0));
            img[0] = enc(1, 0, 0, tbl[i].a);
            img[1] = enc(1, 1, 0, tbl[i].b);
            img[2] = enc(tbl[i].op, 0, 1, tbl[i].imm);
            load();
            run_halt(100);
            reg_rd(0, v);
            chk($sformatf("vec%0d_r0", i), v, tbl[i].er);
            chk($sformatf("vec%0d_flags", i), int'(flags), tbl[i].ef);
            chk($sformatf("vec%0d_pc", i), int'(pc), 4);
        end

        // Counting loop with the input channel always offering 2.
        do_reset();
        fill(enc(0, 0, 0, 0));
        img[15] = 16'd5;
        img[0] = enc(2, 1, 0, 15);
        img[1] = enc(14, 2, 0, 0);
        img[2] = enc(5, 0, 2, 0);
        img[3] = enc(11, 0, 1, 0);
        img[4] = enc(13, 2, 0, 1);
        img[5] = enc(14, 0, 1, 0);
        img[6] = enc(15, 0, 0, 0);
        load();
        in_data = 8'd2; in_valid = 1'b1; out_ready = 1'b1;
        b_in = n_in; b_out = n_out;
        run_halt(300);
        chk("loop_inputs", n_in - b_in, 3);
        chk("loop_outputs", n_out - b_out, 1);
        chk("loop_out_data", last_out, 6);
        chk("loop_pc", int'(pc), 7);
        in_valid = 1'b0;

        // Output backpressure.
        do_reset();
        fill(enc(15, 0, 0, 0));
        img[0] = enc(1, 2, 0, 'h3C);
        img[1] = enc(14, 2, 1, 0);
        img[2] = enc(1, 3, 0, 'h11);
        load();
        run_en = 1'b1;
        wait_ov("bp_valid_seen", 50);
        chk("bp_pc_entry", int'(pc), 2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("bp%0d_valid", k), int'(out_valid), 1);
            chk($sformatf("bp%0d_data", k), int'(out_data), 'h3C);
            chk($sformatf("bp%0d_pc", k), int'(pc), 2);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_valid_drop", int'(out_valid), 0);
        chk("bp_pc_after_hs", int'(pc), 2);
        tick();
        chk("bp_next_fetch", int'(pc), 3);
        run_halt(50);
        reg_rd(3, v);
        chk("bp_r3", v, 'h11);
        chk("bp_data_hold", int'(out_data), 'h3C);

        // Asynchronous reset while waiting in OUT.
        do_reset();
        load();
        run_en = 1'b1;
        wait_ov("ar_valid_seen", 50);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_out_valid", int'(out_valid), 0);
        chk("ar_pc", int'(pc), 0);
        chk("ar_out_data", int'(out_data), 0);
        chk("ar_ir", int'(ir), 0);
        for (int i = 0; i < 4; i++) begin
            reg_rd(i, v);
            chk($sformatf("ar_r%0d", i), v, 0);
        end
        run_en = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("ar_idle_pc", int'(pc), 0);
        chk("ar_idle_valid", int'(out_valid), 0);

        // PC wrap, stop-to-IDLE and program-port lockout.
        do_reset();
        fill(enc(15, 0, 0, 0));
        img[0] = enc(12, 0, 0, 15);
        img[15] = enc(0, 0, 0, 0);
        load();
        run_en = 1'b1;
        for (int k = 0; k < 20 && pc != 4'd15; k++) tick();
        chk("wr_reach15", int'(pc), 15);
        run_en = 1'b0;
        tick();
        tick();
        chk("wr_stop_pc", int'(pc), 15);
        chk("wr_stop_halted", int'(halted), 0);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = enc(1, 3, 0, 'h5A);
        tick();
        prog_we = 1'b0;
        run_en = 1'b1;
        tick();
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = enc(1, 3, 0, 'h11);
        tick();
        chk("wr_wrap_pc", int'(pc), 0);
        run_halt(50);
        prog_we = 1'b0;
        reg_rd(3, v);
        chk("wr_r3", v, 'h5A);
        chk("wr_pc_end", int'(pc), 2);

        // Random straight-line programs against the interpreter.
        for (int t = 0; t < 20; t++) begin
            do_reset();
            for (int a = 0; a < 11; a++) begin
                op = $urandom_range(0, 11);
                if (op == 2 || op == 3)
                    img[a] = enc(op, $urandom_range(0, 3), 0,
                                 $urandom_range(12, 15));
                else
                    img[a] = enc(op, $urandom_range(0, 3),
                                 $urandom_range(0, 3), $urandom_range(0, 255));
            end
            img[11] = enc(15, 0, 0, 0);
            for (int a = 12; a < 16; a++) img[a] = 16'($urandom);
            model_run();
            load();
            run_halt(200);
            for (int i = 0; i < 4; i++) begin
                reg_rd(i, v);
                chk($sformatf("rnd%0d_r%0d", t, i), v, e_reg[i]);
            end
            chk($sformatf("rnd%0d_flags", t), int'(flags), e_fl);
            chk($sformatf("rnd%0d_pc", t), int'(pc), e_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
